// File: rtl/jala_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jala_seq_pkg
//  Purpose  : Shared sequencer state encoding and phase-width helper for the
//             JALA clock sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package jala_seq_pkg;

    // Run-control states; the numeric values are visible on SeqState
    typedef enum logic [1:0] {
        SEQ_INIT = 2'd0,
        SEQ_HALT = 2'd1,
        SEQ_RUN  = 2'd2,
        SEQ_STEP = 2'd3
    } seq_state_t;

    // Width of the phase counter; a single-cycle period still gets one bit
    function automatic int phase_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jala_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module   : jala_phase_counter
//  Purpose  : Modulo-DIV phase counter with enable and synchronous clear.
//             'wrap' is high while the counter sits on its last phase.
//  Revision : 1.0  initial release
// ============================================================================
module jala_phase_counter #(
    parameter int DIV = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] phase,
    output logic         wrap
);

    localparam logic [W-1:0] c_LAST = W'(DIV - 1);

    logic [W-1:0] r_phase;

    assign wrap  = (r_phase == c_LAST);
    assign phase = r_phase;

    // Advance one phase per enabled cycle, folding back to zero after the last
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= wrap ? '0 : r_phase + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jala_clock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : jala_clock_sequencer
//  Purpose  : Single-clock run-control and phase sequencer for the JALA stack
//             CPU. Produces datapath/control enables, run/halt/single-step
//             control and a saturating retired-control-period counter.
//  Options  : JALA_SEQ_BREAKPOINT_EN adds PCIn/BreakAddr/BreakHit and a PC
//             breakpoint that behaves like a Halt request.
//  Revision : 1.0  initial release
// ============================================================================
module jala_clock_sequencer
    import jala_seq_pkg::*;
#(
    parameter int CTRL_DIV      = 2,
    parameter int OFFSET_CYCLES = 1,
    parameter bit AUTO_RUN      = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                             CLK,
    input  logic                             CtrlRst,
    input  logic                             Run,
    input  logic                             Halt,
    input  logic                             Step,
`ifdef JALA_SEQ_BREAKPOINT_EN
    input  logic [15:0]                      PCIn,
    input  logic [15:0]                      BreakAddr,
    output logic                             BreakHit,
`endif
    output logic                             DpEn,
    output logic                             CtrlEn,
    output logic [phase_width(CTRL_DIV)-1:0] CtrlPhase,
    output logic [1:0]                       SeqState,
    output logic [CNT_W-1:0]                 CycleCount,
    output logic                             StepDone
);

    localparam int c_PH_W     = phase_width(CTRL_DIV);
    // INIT always lasts at least one cycle; OFFSET_CYCLES above one stretches it
    localparam int c_OFF_MAX  = (OFFSET_CYCLES > 0) ? OFFSET_CYCLES - 1 : 0;
    localparam int c_OFF_W    = (c_OFF_MAX > 0) ? $clog2(c_OFF_MAX + 1) : 1;
    localparam logic [c_OFF_W-1:0] c_OFF_LAST = c_OFF_W'(c_OFF_MAX);

    seq_state_t         r_state;
    logic [c_OFF_W-1:0] r_off_cnt;
    logic               r_halt_pend;
    logic               r_step_prev;
    logic               r_step_done;
    logic [CNT_W-1:0]   r_cycle_cnt;

    logic               w_active;
    logic               w_wrap;
    logic               w_ctrl_en;
    logic               w_step_req;
    logic               w_bp_match;
    logic [c_PH_W-1:0]  w_phase;

    // Enables derive purely from state and phase registers
    assign w_active   = (r_state == SEQ_RUN) || (r_state == SEQ_STEP);
    assign w_ctrl_en  = w_active && w_wrap;
    // A held Step only counts once it has been seen low
    assign w_step_req = Step && !r_step_prev;

`ifdef JALA_SEQ_BREAKPOINT_EN
    logic r_break_hit;
    assign w_bp_match = (r_state == SEQ_RUN) && w_ctrl_en && (PCIn == BreakAddr);
    assign BreakHit   = r_break_hit;
`else
    assign w_bp_match = 1'b0;
`endif

    jala_phase_counter #(
        .DIV (CTRL_DIV),
        .W   (c_PH_W)
    ) u_phase (
        .clk   (CLK),
        .rst   (CtrlRst),
        .en    (w_active),
        .clr   (!w_active),
        .phase (w_phase),
        .wrap  (w_wrap)
    );

    // Run-control FSM: INIT offset, halt alignment to period boundaries, stepping
    always_ff @(posedge CLK) begin
        if (CtrlRst) begin
            r_state     <= SEQ_INIT;
            r_off_cnt   <= '0;
            r_halt_pend <= 1'b0;
            r_step_prev <= 1'b0;
            r_step_done <= 1'b0;
`ifdef JALA_SEQ_BREAKPOINT_EN
            r_break_hit <= 1'b0;
`endif
        end else begin
            r_step_prev <= Step;
            r_step_done <= 1'b0;
            case (r_state)
                SEQ_INIT: begin
                    if (r_off_cnt == c_OFF_LAST) begin
                        r_state <= AUTO_RUN ? SEQ_RUN : SEQ_HALT;
                    end else begin
                        r_off_cnt <= r_off_cnt + 1'b1;
                    end
                end
                SEQ_RUN: begin
                    // Only stop on the last phase so a period is never cut short
                    if (w_ctrl_en && (r_halt_pend || Halt || w_bp_match)) begin
                        r_state     <= SEQ_HALT;
                        r_halt_pend <= 1'b0;
`ifdef JALA_SEQ_BREAKPOINT_EN
                        r_break_hit <= w_bp_match;
`endif
                    end else if (Halt) begin
                        r_halt_pend <= 1'b1;
                    end
                end
                SEQ_HALT: begin
                    if (!Halt) begin
                        if (w_step_req) begin
                            r_state <= SEQ_STEP;
`ifdef JALA_SEQ_BREAKPOINT_EN
                            r_break_hit <= 1'b0;
`endif
                        end else if (Run) begin
                            r_state <= SEQ_RUN;
`ifdef JALA_SEQ_BREAKPOINT_EN
                            r_break_hit <= 1'b0;
`endif
                        end
                    end
                end
                SEQ_STEP: begin
                    if (w_wrap) begin
                        r_state     <= SEQ_HALT;
                        r_step_done <= 1'b1;
                    end
                end
                default: r_state <= SEQ_INIT;
            endcase
        end
    end

    // Count every completed control period, sticking at all-ones
    always_ff @(posedge CLK) begin
        if (CtrlRst) begin
            r_cycle_cnt <= '0;
        end else if (w_ctrl_en && !(&r_cycle_cnt)) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign DpEn       = w_active;
    assign CtrlEn     = w_ctrl_en;
    assign CtrlPhase  = w_phase;
    assign SeqState   = r_state;
    assign CycleCount = r_cycle_cnt;
    assign StepDone   = r_step_done;

endmodule
`default_nettype wire

// File: tb/tb_jala_clock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jala_clock_sequencer
//  Purpose  : Scoreboard bench for jala_clock_sequencer. Four instances with
//             different parameter sets; expected output events are queued by
//             the stimulus and matched by a negedge monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jala_clock_sequencer;

    localparam int ST_INIT = 0;
    localparam int ST_HALT = 1;
    localparam int ST_RUN  = 2;
    localparam int ST_STEP = 3;

    logic CLK;
    logic rst0, rst1, rst2, rst3;
    logic run, halt, step;
    logic [15:0] pc, brk;

    logic [1:0]  st0, st1, st2, st3;
    logic        dp0, dp1, dp2, dp3;
    logic        ce0, ce1, ce2, ce3;
    logic        sd0, sd1, sd2, sd3;
    logic [0:0]  ph0, ph3;
    logic [1:0]  ph1, ph2;
    logic [15:0] cnt0, cnt1, cnt2;
    logic [3:0]  cnt3;
    logic        bh0, bh1, bh2, bh3;

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 1'b0;
    int prev_st [4];

    typedef struct {
        int id; int cyc; int st; int dp; int ph; int ce; int sd; int cnt; int bh;
    } ev_t;
    ev_t exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    jala_clock_sequencer #(.CTRL_DIV(2), .OFFSET_CYCLES(1), .AUTO_RUN(1'b1), .CNT_W(16)) u_a (
        .CLK(CLK), .CtrlRst(rst0), .Run(run), .Halt(halt), .Step(step),
`ifdef JALA_SEQ_BREAKPOINT_EN
        .PCIn(pc), .BreakAddr(brk), .BreakHit(bh0),
`endif
        .DpEn(dp0), .CtrlEn(ce0), .CtrlPhase(ph0), .SeqState(st0), .CycleCount(cnt0), .StepDone(sd0));

    jala_clock_sequencer #(.CTRL_DIV(4), .OFFSET_CYCLES(1), .AUTO_RUN(1'b1), .CNT_W(16)) u_b (
        .CLK(CLK), .CtrlRst(rst1), .Run(run), .Halt(halt), .Step(step),
`ifdef JALA_SEQ_BREAKPOINT_EN
        .PCIn(pc), .BreakAddr(brk), .BreakHit(bh1),
`endif
        .DpEn(dp1), .CtrlEn(ce1), .CtrlPhase(ph1), .SeqState(st1), .CycleCount(cnt1), .StepDone(sd1));

    jala_clock_sequencer #(.CTRL_DIV(3), .OFFSET_CYCLES(1), .AUTO_RUN(1'b0), .CNT_W(16)) u_c (
        .CLK(CLK), .CtrlRst(rst2), .Run(run), .Halt(halt), .Step(step),
`ifdef JALA_SEQ_BREAKPOINT_EN
        .PCIn(pc), .BreakAddr(brk), .BreakHit(bh2),
`endif
        .DpEn(dp2), .CtrlEn(ce2), .CtrlPhase(ph2), .SeqState(st2), .CycleCount(cnt2), .StepDone(sd2));

    jala_clock_sequencer #(.CTRL_DIV(1), .OFFSET_CYCLES(1), .AUTO_RUN(1'b1), .CNT_W(4)) u_d (
        .CLK(CLK), .CtrlRst(rst3), .Run(run), .Halt(halt), .Step(step),
`ifdef JALA_SEQ_BREAKPOINT_EN
        .PCIn(pc), .BreakAddr(brk), .BreakHit(bh3),
`endif
        .DpEn(dp3), .CtrlEn(ce3), .CtrlPhase(ph3), .SeqState(st3), .CycleCount(cnt3), .StepDone(sd3));

`ifndef JALA_SEQ_BREAKPOINT_EN
    assign bh0 = 1'b0;
    assign bh1 = 1'b0;
    assign bh2 = 1'b0;
    assign bh3 = 1'b0;
`endif

    function automatic void exp_ev(input int id, input int c, input int st, input int dp, input int ph,
                                   input int ce, input int sd, input int cnt, input int bh);
        ev_t e;
        e.id = id; e.cyc = c; e.st = st; e.dp = dp; e.ph = ph;
        e.ce = ce; e.sd = sd; e.cnt = cnt; e.bh = bh;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // An event is a CtrlEn pulse, a StepDone pulse or a state change
    task automatic observe(input int id, input int st, input int dp, input int ph, input int ce,
                           input int sd, input int cnt, input int bh);
        ev_t e;
        if (mon_en && (ce != 0 || sd != 0 || st != prev_st[id])) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event dut=%0d cyc=%0d: got st=%0d ce=%0d sd=%0d cnt=%0d, required no event",
                         id, cyc, st, ce, sd, cnt);
            end else begin
                e = exp_q.pop_front();
                if (e.id != id || e.cyc != cyc || e.st != st || e.dp != dp || e.ph != ph ||
                    e.ce != ce || e.sd != sd || e.cnt != cnt || e.bh != bh) begin
                    n_err++;
                    $display("FAIL event: got dut=%0d cyc=%0d st=%0d dp=%0d ph=%0d ce=%0d sd=%0d cnt=%0d bh=%0d, required dut=%0d cyc=%0d st=%0d dp=%0d ph=%0d ce=%0d sd=%0d cnt=%0d bh=%0d",
                             id, cyc, st, dp, ph, ce, sd, cnt, bh,
                             e.id, e.cyc, e.st, e.dp, e.ph, e.ce, e.sd, e.cnt, e.bh);
                end
            end
        end
        prev_st[id] = st;
    endtask

    // Monitor: sample all instances mid-cycle
    always @(negedge CLK) begin
        observe(0, int'(st0), int'(dp0), int'(ph0), int'(ce0), int'(sd0), int'(cnt0), int'(bh0));
        observe(1, int'(st1), int'(dp1), int'(ph1), int'(ce1), int'(sd1), int'(cnt1), int'(bh1));
        observe(2, int'(st2), int'(dp2), int'(ph2), int'(ce2), int'(sd2), int'(cnt2), int'(bh2));
        observe(3, int'(st3), int'(dp3), int'(ph3), int'(ce3), int'(sd3), int'(cnt3), int'(bh3));
    end

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Defaults: one INIT cycle, then CtrlEn every second cycle; reset mid-RUN
    task automatic test_defaults();
        int b;
        b = cyc;
        exp_ev(0, b + 1, ST_RUN, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) exp_ev(0, b + 2 + 2 * k, ST_RUN, 1, 1, 1, 0, k, 0);
        exp_ev(0, b + 9, ST_INIT, 0, 0, 0, 0, 0, 0);
        rst0 = 1'b0;
        at(b + 8);
        rst0 = 1'b1;
        at(b + 11);
    endtask

    // CTRL_DIV=4: halt waits for the wrap; Halt beats Run
    task automatic test_halt_align();
        int b;
        b = cyc;
        exp_ev(1, b + 1,  ST_RUN,  1, 0, 0, 0, 0, 0);
        exp_ev(1, b + 4,  ST_RUN,  1, 3, 1, 0, 0, 0);
        exp_ev(1, b + 8,  ST_RUN,  1, 3, 1, 0, 1, 0);
        exp_ev(1, b + 12, ST_RUN,  1, 3, 1, 0, 2, 0);
        exp_ev(1, b + 13, ST_HALT, 0, 0, 0, 0, 3, 0);
        exp_ev(1, b + 15, ST_RUN,  1, 0, 0, 0, 3, 0);
        exp_ev(1, b + 18, ST_RUN,  1, 3, 1, 0, 3, 0);
        exp_ev(1, b + 19, ST_HALT, 0, 0, 0, 0, 4, 0);
        exp_ev(1, b + 21, ST_RUN,  1, 0, 0, 0, 4, 0);
        exp_ev(1, b + 22, ST_INIT, 0, 0, 0, 0, 0, 0);
        rst1 = 1'b0;
        at(b + 10); halt = 1'b1;
        at(b + 11); halt = 1'b0;
        at(b + 14); run  = 1'b1;
        at(b + 15); halt = 1'b1;
        at(b + 20); halt = 1'b0;
        at(b + 21); rst1 = 1'b1; run = 1'b0;
        at(b + 24);
    endtask

    // CTRL_DIV=3, AUTO_RUN=0: step, held Step, Run+Step priority, reset mid-STEP
    task automatic test_step();
        int b;
        b = cyc;
        exp_ev(2, b + 1,  ST_HALT, 0, 0, 0, 0, 0, 0);
        exp_ev(2, b + 3,  ST_STEP, 1, 0, 0, 0, 0, 0);
        exp_ev(2, b + 5,  ST_STEP, 1, 2, 1, 0, 0, 0);
        exp_ev(2, b + 6,  ST_HALT, 0, 0, 0, 1, 1, 0);
        exp_ev(2, b + 9,  ST_STEP, 1, 0, 0, 0, 1, 0);
        exp_ev(2, b + 11, ST_STEP, 1, 2, 1, 0, 1, 0);
        exp_ev(2, b + 12, ST_HALT, 0, 0, 0, 1, 2, 0);
        exp_ev(2, b + 19, ST_STEP, 1, 0, 0, 0, 2, 0);
        exp_ev(2, b + 21, ST_INIT, 0, 0, 0, 0, 0, 0);
        rst2 = 1'b0;
        at(b + 2);  step = 1'b1;
        at(b + 3);  step = 1'b0;
        at(b + 8);  step = 1'b1;
        at(b + 16); step = 1'b0;
        at(b + 18); step = 1'b1; run = 1'b1;
        at(b + 20); rst2 = 1'b1; step = 1'b0; run = 1'b0;
        at(b + 23);
    endtask

`ifdef JALA_SEQ_BREAKPOINT_EN
    // Breakpoint at 0x0010 halts on the boundary; Step moves off it
    task automatic test_breakpoint();
        int b;
        b = cyc;
        exp_ev(2, b + 1,  ST_HALT, 0, 0, 0, 0, 0, 0);
        exp_ev(2, b + 3,  ST_RUN,  1, 0, 0, 0, 0, 0);
        exp_ev(2, b + 5,  ST_RUN,  1, 2, 1, 0, 0, 0);
        exp_ev(2, b + 8,  ST_RUN,  1, 2, 1, 0, 1, 0);
        exp_ev(2, b + 9,  ST_HALT, 0, 0, 0, 0, 2, 1);
        exp_ev(2, b + 11, ST_STEP, 1, 0, 0, 0, 2, 0);
        exp_ev(2, b + 13, ST_STEP, 1, 2, 1, 0, 2, 0);
        exp_ev(2, b + 14, ST_HALT, 0, 0, 0, 1, 3, 0);
        exp_ev(2, b + 16, ST_INIT, 0, 0, 0, 0, 0, 0);
        rst2 = 1'b0; pc = 16'h0000; brk = 16'h0010;
        at(b + 2);  run  = 1'b1;
        at(b + 3);  run  = 1'b0;
        at(b + 7);  pc   = 16'h0010;
        at(b + 10); step = 1'b1;
        at(b + 11); step = 1'b0;
        at(b + 15); rst2 = 1'b1; pc = 16'h0000; brk = 16'hFFFF;
        at(b + 18);
    endtask
`endif

    // CTRL_DIV=1, CNT_W=4: CtrlEn every cycle, counter sticks at 15
    task automatic test_saturate();
        int b;
        b = cyc;
        for (int k = 1; k <= 20; k++) exp_ev(3, b + k, ST_RUN, 1, 0, 1, 0, (k - 1 > 15) ? 15 : k - 1, 0);
        exp_ev(3, b + 21, ST_INIT, 0, 0, 0, 0, 0, 0);
        rst3 = 1'b0;
        at(b + 20);
        rst3 = 1'b1;
        at(b + 23);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        run = 1'b0; halt = 1'b0; step = 1'b0;
        pc = 16'h0000; brk = 16'hFFFF;
        at(3);
        check("reset_state_a", int'(st0), ST_INIT);
        check("reset_dpen_a",  int'(dp0), 0);
        check("reset_ctrlen_a", int'(ce0), 0);
        check("reset_phase_a", int'(ph0), 0);
        check("reset_count_a", int'(cnt0), 0);
        check("reset_stepdone_a", int'(sd0), 0);
        check("reset_state_d", int'(st3), ST_INIT);
        check("reset_count_d", int'(cnt3), 0);
        mon_en = 1'b1;
        test_defaults();
        test_halt_align();
        test_step();
`ifdef JALA_SEQ_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_saturate();
        at(cyc + 3);
        check("events_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
